// File: rtl/fifo_512_byte_pkg.sv
// fifo_512_byte_pkg: shared encoding of the per-cycle FIFO operation.
package fifo_512_byte_pkg;
    typedef enum logic [1:0] {OP_IDLE, OP_WR, OP_RD, OP_RW} fifo_op_e;
endpackage

// File: rtl/fifo_sdp_ram.sv
// fifo_sdp_ram: simple dual-port RAM with a registered read port, shaped for block RAM inference.
module fifo_sdp_ram #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 512,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Output register reset only; the array itself is never cleared.
    always_ff @(posedge clk) begin
        if (rst) rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/fifo_512_byte.sv
// fifo_512_byte: single-clock byte FIFO with registered fill count and empty/full flags.
module fifo_512_byte
    import fifo_512_byte_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 512,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] current_fill_ct,
    output logic              fifo_empty,
    output logic              fifo_full
);
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_q, count_d;
    logic              empty_q, empty_d, full_q, full_d;
    logic              wr_acc, rd_acc;
    fifo_op_e          op;

    // A full FIFO still takes a write when a read frees a slot in the same cycle.
    always_comb begin
        wr_acc   = en & wr_en & (~full_q | rd_en);
        rd_acc   = en & rd_en & ~empty_q;
        op       = fifo_op_e'({rd_acc, wr_acc});
        wr_ptr_d = wr_ptr_q + ADDR_W'(wr_acc);
        rd_ptr_d = rd_ptr_q + ADDR_W'(rd_acc);
        count_d  = op == OP_WR ? count_q + 1'b1 : op == OP_RD ? count_q - 1'b1 : count_q;
        empty_d  = count_d == '0;
        full_d   = count_d == ADDR_W'(DEPTH - 1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
        end
    end

    fifo_sdp_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_acc),
        .waddr (wr_ptr_q),
        .wdata (wr_data),
        .re    (rd_acc),
        .raddr (rd_ptr_q),
        .rdata (rd_data)
    );

    assign current_fill_ct = count_q;
    assign fifo_empty      = empty_q;
    assign fifo_full       = full_q;
endmodule

// File: tb/tb_fifo_512_byte.sv
// tb_fifo_512_byte: random and directed stimulus checked every cycle against a queue model.
module tb_fifo_512_byte;
    logic       clk, rst, en, wr_en, rd_en;
    logic [7:0] wr_data, rd_data;
    logic [8:0] current_fill_ct;
    logic       fifo_empty, fifo_full;
    int         tests = 0, fails = 0;
    bit         chk_on = 0;
    logic [7:0] q[$];
    logic [7:0] m_rd = 8'h00;

    fifo_512_byte dut (
        .clk             (clk),
        .rst             (rst),
        .en              (en),
        .wr_en           (wr_en),
        .wr_data         (wr_data),
        .rd_en           (rd_en),
        .rd_data         (rd_data),
        .current_fill_ct (current_fill_ct),
        .fifo_empty      (fifo_empty),
        .fifo_full       (fifo_full)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string n, input int a, input int e);
        tests++;
        if (a != e) begin
            fails++;
            $display("FAIL %s actual=%0d required=%0d", n, a, e);
        end
    endtask

    // Reference: a queue of stored words with capacity 511.
    always @(posedge clk) begin : mdl
        bit ra, wa;
        if (rst) begin
            q.delete();
            m_rd = 8'h00;
        end else if (en) begin
            ra = rd_en && q.size() > 0;
            wa = wr_en && (q.size() < 511 || rd_en);
            if (ra) m_rd = q.pop_front();
            if (wa) q.push_back(wr_data);
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("rd_data", int'(rd_data), int'(m_rd));
            chk("fill_ct", int'(current_fill_ct), q.size());
            chk("empty", int'(fifo_empty), int'(q.size() == 0));
            chk("full", int'(fifo_full), int'(q.size() == 511));
        end
    end

    task automatic cyc(input bit e, input bit w, input logic [7:0] d, input bit r);
        @(negedge clk);
        en = e; wr_en = w; wr_data = d; rd_en = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] basic [3];
        basic = '{8'h11, 8'h22, 8'h33};
        en = 1; rst = 1; wr_en = 0; rd_en = 0; wr_data = 0;
        repeat (2) cyc(1, 0, 8'h00, 0);
        rst = 0;
        chk_on = 1;
        chk("rst_cnt", int'(current_fill_ct), 0);
        chk("rst_empty", int'(fifo_empty), 1);
        chk("rst_full", int'(fifo_full), 0);
        chk("rst_rd", int'(rd_data), 0);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 1, basic[i], 0);
            chk("basic_wcnt", int'(current_fill_ct), i + 1);
        end
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 8'h00, 1);
            chk("basic_rd", int'(rd_data), int'(basic[i]));
            chk("basic_rcnt", int'(current_fill_ct), 2 - i);
        end
        chk("basic_empty", int'(fifo_empty), 1);
        for (int i = 0; i < 511; i++) cyc(1, 1, i[7:0], 0);
        chk("fill_full", int'(fifo_full), 1);
        chk("fill_cnt", int'(current_fill_ct), 511);
        cyc(1, 1, 8'hAA, 0);
        chk("ovf_cnt", int'(current_fill_ct), 511);
        for (int i = 0; i < 511; i++) begin
            cyc(1, 0, 8'h00, 1);
            chk("drain_rd", int'(rd_data), int'(i[7:0]));
        end
        chk("drain_empty", int'(fifo_empty), 1);
        cyc(1, 0, 8'h00, 1);
        chk("udf_rd", int'(rd_data), 'hFE);
        chk("udf_cnt", int'(current_fill_ct), 0);
        cyc(1, 1, 8'h3C, 0);
        cyc(1, 0, 8'h00, 1);
        chk("udf_after", int'(rd_data), 'h3C);
        for (int i = 0; i < 511; i++) cyc(1, 1, 8'((i + 7) & 'hFF), 0);
        cyc(1, 1, 8'h5A, 1);
        chk("rw_full_cnt", int'(current_fill_ct), 511);
        chk("rw_full_rd", int'(rd_data), 'h07);
        repeat (511) cyc(1, 0, 8'h00, 1);
        chk("rw_full_last", int'(rd_data), 'h5A);
        cyc(1, 1, 8'hC3, 1);
        chk("rw_empty_cnt", int'(current_fill_ct), 1);
        chk("rw_empty_rd", int'(rd_data), 'h5A);
        cyc(1, 0, 8'h00, 1);
        chk("rw_empty_next", int'(rd_data), 'hC3);
        cyc(1, 1, 8'h01, 0);
        repeat (5) cyc(0, 1, 8'($urandom), 1);
        chk("en_cnt", int'(current_fill_ct), 1);
        chk("en_rd", int'(rd_data), 'hC3);
        repeat (1000) cyc(1, 1, 8'($urandom), 1);
        chk("stream_cnt", int'(current_fill_ct), 1);
        for (int ph = 0; ph < 6; ph++) begin
            int wp;
            wp = (ph % 2 == 0) ? 85 : 25;
            repeat (600) cyc($urandom_range(0, 9) != 0, $urandom_range(0, 99) < wp,
                             8'($urandom), $urandom_range(0, 99) < 50);
        end
        rst = 1;
        cyc(1, 1, 8'h55, 1);
        rst = 0;
        chk("rst2_cnt", int'(current_fill_ct), 0);
        chk("rst2_rd", int'(rd_data), 0);
        chk("rst2_empty", int'(fifo_empty), 1);
        cyc(1, 0, 8'h00, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
